// File: rtl/pipelined_register_file_if.sv
// pipelined_register_file_if
// Bundles the decode/write-back side of the TinyCPU register file.
// master: decode + write-back logic (drives requests, observes results).
// slave : the register file itself.
// Signals:
//   read_reg_0/1, read_en_0/1   decode read addresses and port enables
//   issue_valid, issue_reg      destination of an issuing register-writing instruction
//   write_address/data/enable   write-back port
//   read_data_0/1, read_valid   registered read results
//   stall                       combinational hold request to decode
//   busy                        pending-write scoreboard (debug)
interface pipelined_register_file_if #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [4:0]            read_reg_0;
    logic [4:0]            read_reg_1;
    logic                  read_en_0;
    logic                  read_en_1;
    logic                  issue_valid;
    logic [4:0]            issue_reg;
    logic [4:0]            write_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] read_data_0;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic                  read_valid;
    logic                  stall;
    logic [NUM_REGS-1:0]   busy;

    modport master (
        output read_reg_0, read_reg_1, read_en_0, read_en_1,
        output issue_valid, issue_reg,
        output write_address, write_data, write_enable,
        input  read_data_0, read_data_1, read_valid, stall, busy
    );

    modport slave (
        input  read_reg_0, read_reg_1, read_en_0, read_en_1,
        input  issue_valid, issue_reg,
        input  write_address, write_data, write_enable,
        output read_data_0, read_data_1, read_valid, stall, busy
    );
endinterface

// File: rtl/pipelined_register_file.sv
// pipelined_register_file
// Architectural register file with a pending-write scoreboard. Decode is
// stalled while it reads (RAW) or re-targets (WAW) a register whose write is
// still in flight. Read data is registered: one cycle latency.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   rf     pipelined_register_file_if.slave (read, issue, write-back, results)
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle
// write-back data to reads and let a matching write-back cancel the hazard
// and WAW stall terms.
module pipelined_register_file #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic                      clk,
    input logic                      rst_n,
    pipelined_register_file_if.slave rf
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [DATA_WIDTH-1:0] read_data_0_q;
    logic [DATA_WIDTH-1:0] read_data_1_q;
    logic                  read_valid_q;

    logic bypass_hit_0;
    logic bypass_hit_1;
    logic wb_hits_issue;
    logic hazard_0;
    logic hazard_1;
    logic waw;
    logic stall;

`ifdef REG_FILE_BYPASS_EN
    assign bypass_hit_0  = rf.write_enable && (rf.write_address == rf.read_reg_0);
    assign bypass_hit_1  = rf.write_enable && (rf.write_address == rf.read_reg_1);
    // A write-back to the issue target frees it on this very edge.
    assign wb_hits_issue = rf.write_enable && (rf.write_address == rf.issue_reg);
`else
    assign bypass_hit_0  = 1'b0;
    assign bypass_hit_1  = 1'b0;
    assign wb_hits_issue = 1'b0;
`endif

    assign hazard_0 = rf.read_en_0 && busy_q[rf.read_reg_0] && !bypass_hit_0;
    assign hazard_1 = rf.read_en_1 && busy_q[rf.read_reg_1] && !bypass_hit_1;
    assign waw      = rf.issue_valid && busy_q[rf.issue_reg] && !wb_hits_issue;
    assign stall    = hazard_0 || hazard_1 || waw;

    // Clear first, then set, so an issue to the register being written back wins.
    always_comb begin
        busy_d = busy_q;
        if (rf.write_enable) begin
            busy_d[rf.write_address] = 1'b0;
        end
        if (rf.issue_valid && !stall) begin
            busy_d[rf.issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf.write_enable) begin
            regs_q[rf.write_address] <= rf.write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            read_data_0_q <= '0;
            read_data_1_q <= '0;
            read_valid_q  <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            // Disabled ports still capture; the consumer ignores them.
            read_data_0_q <= bypass_hit_0 ? rf.write_data : regs_q[rf.read_reg_0];
            read_data_1_q <= bypass_hit_1 ? rf.write_data : regs_q[rf.read_reg_1];
            read_valid_q  <= (rf.read_en_0 || rf.read_en_1) && !stall;
        end
    end

    assign rf.read_data_0 = read_data_0_q;
    assign rf.read_data_1 = read_data_1_q;
    assign rf.read_valid  = read_valid_q;
    assign rf.stall       = stall;
    assign rf.busy        = busy_q;

endmodule
